// File: rtl/decoder_3to8_if.sv
// Purpose : select-code / decoded-output bundle for the registered 3-to-8 decoder.
// Ports   : in_1 (select MSB), in_2, in_3 (select LSB) from master; out[7:0] one-hot from slave.
// Latency/backpressure: none at this level; no handshake, a new code every cycle.
interface decoder_3to8_if;

  logic       in_1;  // select bit 2 (MSB)
  logic       in_2;  // select bit 1
  logic       in_3;  // select bit 0 (LSB)
  logic [7:0] out;   // registered decoded lines

  // Master: whoever supplies the select code and consumes the decoded lines.
  modport master (
    output in_1,
    output in_2,
    output in_3,
    input  out
  );

  // Slave: the decoder itself.
  modport slave (
    input  in_1,
    input  in_2,
    input  in_3,
    output out
  );

endinterface

// File: rtl/decoder_3to8.sv
// Purpose : registered 3-to-8 line decoder, sel = {in_1,in_2,in_3} asserts out[sel].
// Latency : 1 sys_clk cycle from sampled inputs to out; reset (sync, active-high) wins.
// Backpressure: none; accepts a code and updates out on every rising edge.
//
// Ports:
//   sys_clk  in  1  rising-edge clock
//   sys_rst  in  1  synchronous active-high reset, drives out to "no line selected"
//   dec_if   slave modport of decoder_3to8_if (in_1/in_2/in_3 in, out[7:0] out)
//
// Build option DECODER_ACTIVE_LOW_EN: when defined, out is active-low
// (74HC138 style, out = ~onehot) and resets to 8'hFF; otherwise active-high
// one-hot with reset value 8'h00. The inversion sits in front of the
// register so latency does not change.
module decoder_3to8 (
  input  logic            sys_clk,
  input  logic            sys_rst,
  decoder_3to8_if.slave   dec_if
);

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [7:0] OUT_RST_VAL = 8'hFF;
`else
  localparam logic [7:0] OUT_RST_VAL = 8'h00;
`endif

  logic [2:0] sel;
  logic [7:0] onehot;
  logic [7:0] out_d;
  logic [7:0] out_q;

  assign sel = {dec_if.in_1, dec_if.in_2, dec_if.in_3};

  // Full case table. The default arm only matters for X/Z selects, where no
  // line should be driven active; it yields the same "nothing selected"
  // pattern as reset.
  always_comb begin
    onehot = 8'h00;
    case (sel)
      3'b000:  onehot = 8'b0000_0001;
      3'b001:  onehot = 8'b0000_0010;
      3'b010:  onehot = 8'b0000_0100;
      3'b011:  onehot = 8'b0000_1000;
      3'b100:  onehot = 8'b0001_0000;
      3'b101:  onehot = 8'b0010_0000;
      3'b110:  onehot = 8'b0100_0000;
      3'b111:  onehot = 8'b1000_0000;
      default: onehot = 8'h00;
    endcase
  end

  // Polarity applied before the register so both builds share one flop stage.
  always_comb begin
`ifdef DECODER_ACTIVE_LOW_EN
    out_d = ~onehot;
`else
    out_d = onehot;
`endif
  end

  // Reset value is intentionally not the 000 decode: downstream chip-selects
  // must all be inactive while in reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_q <= OUT_RST_VAL;
    end else begin
      out_q <= out_d;
    end
  end

  assign dec_if.out = out_q;

  // Active-high view of the registered output, used only by the check below.
  logic [7:0] out_ah;
`ifdef DECODER_ACTIVE_LOW_EN
  assign out_ah = ~out_q;
`else
  assign out_ah = out_q;
`endif

  // Any edge taken out of reset must leave exactly one line selected.
  a_onehot_out: assert property (@(posedge sys_clk) !sys_rst |=> $onehot(out_ah));

endmodule

// File: tb/tb_decoder_3to8.sv
module tb_decoder_3to8;

  logic sys_clk = 1'b0;
  logic sys_rst;

  decoder_3to8_if dec_if ();

  decoder_3to8 dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .dec_if  (dec_if.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Polarity of the build under test.
  function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] s);
    dec_if.in_1 = s[2];
    dec_if.in_2 = s[1];
    dec_if.in_3 = s[0];
  endtask

  // Reference model: the output after an edge is the reset pattern if reset
  // was high at that edge, else a single bit at position sel, polarity applied.
  logic       model_vld = 1'b0;
  logic       model_rst;
  logic [7:0] model_out;

  always @(posedge sys_clk) begin
    model_vld <= 1'b1;
    model_rst <= sys_rst;
    if (sys_rst) begin
      model_out <= pol(8'h00);
    end else begin
      model_out <= pol(8'd1 << {dec_if.in_1, dec_if.in_2, dec_if.in_3});
    end
  end

  // Every cycle: DUT against model, plus one-hot invariant outside reset.
  always @(negedge sys_clk) begin
    if (model_vld) begin
      check("model", dec_if.out, model_out);
      if (!model_rst) begin
        check("onehot", {7'd0, $onehot(pol(dec_if.out))}, 8'h01);
      end
    end
  end

  // Hand-computed active-high decode of 000..111.
  logic [7:0] sweep_lit [8];

  initial begin
    sweep_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Reset held two cycles with random inputs.
    sys_rst = 1'b1;
    drive(3'($urandom_range(0, 7)));
    repeat (2) begin
      @(posedge sys_clk); #1;
      drive(3'($urandom_range(0, 7)));
    end
`ifdef DECODER_ACTIVE_LOW_EN
    check("reset_val", dec_if.out, 8'hFF);
`else
    check("reset_val", dec_if.out, 8'h00);
`endif

    // Sweep all codes, one per cycle, starting on the first non-reset edge.
    sys_rst = 1'b0;
    drive(3'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge sys_clk); #1;
      check($sformatf("sweep_%0d", i), dec_if.out, pol(sweep_lit[i]));
      drive(3'(i + 1));
    end
`ifdef DECODER_ACTIVE_LOW_EN
    // Active-low literals for the end codes.
    drive(3'd0);
    @(posedge sys_clk); #1;
    check("al_000", dec_if.out, 8'hFE);
    drive(3'd7);
    @(posedge sys_clk); #1;
    check("al_111", dec_if.out, 8'h7F);
`endif

    // Input change between edges must not show until the next edge.
    drive(3'b011);
    @(posedge sys_clk); #1;
    check("hold_a", dec_if.out, pol(8'h08));
    #1 drive(3'b110);
    #1 check("hold_mid", dec_if.out, pol(8'h08));
    @(posedge sys_clk); #1;
    check("hold_b", dec_if.out, pol(8'h40));

    // Mid-stream reset, then release with the same select.
    drive(3'b101);
    @(posedge sys_clk); #1;
    check("rst_pre", dec_if.out, pol(8'h20));
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    check("rst_mid", dec_if.out, pol(8'h00));
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("rst_post", dec_if.out, pol(8'h20));

    // Random stream; compared every cycle by the compare process.
    repeat (1000) begin
      drive(3'($urandom_range(0, 7)));
      @(posedge sys_clk); #1;
    end

    // Occasional random resets mixed into the stream.
    repeat (200) begin
      sys_rst = ($urandom_range(0, 7) == 0);
      drive(3'($urandom_range(0, 7)));
      @(posedge sys_clk); #1;
    end
    sys_rst = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
